// File: rtl/sa_wdata_steer_pkg.sv
// Shared width helpers for the write-data steering stage.
// Order entries carry {id,len}; W entries carry {data,strb,last}.
package sa_pkg;

   function automatic int order_entry_w(int id_w, int len_w);
      return id_w + len_w;
   endfunction

   function automatic int wentry_w(int data_w);
      return data_w + data_w / 8 + 1;
   endfunction

endpackage

// File: rtl/sa_wdata_steer_if.sv
// Dispatcher-side W beats, AW order pushes and the slave W channel.
// The steering block takes the slave modport; its feeders take master.
interface sa_wdata_steer_if #(
   parameter int MST_AMT          = 3,
   parameter int MST_ID_W         = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
   parameter int DATA_WIDTH       = 32,
   parameter int STRB_WIDTH       = DATA_WIDTH / 8,
   parameter int TRANS_DATA_LEN_W = 8
);
   logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i;
   logic [STRB_WIDTH*MST_AMT-1:0] dsp_WSTRB_i;
   logic [MST_AMT-1:0]            dsp_WLAST_i;
   logic [MST_AMT-1:0]            dsp_WVALID_i;
   logic [MST_AMT-1:0]            dsp_slv_sel_i;
   logic [MST_AMT-1:0]            dsp_WREADY_o;
   logic [MST_ID_W-1:0]           AW_mst_id_i;
   logic [TRANS_DATA_LEN_W-1:0]   AW_AxLEN_i;
   logic                          AW_fifo_order_wr_en_i;
   logic                          AW_stall_o;
   logic [DATA_WIDTH-1:0]         s_WDATA_o;
   logic [STRB_WIDTH-1:0]         s_WSTRB_o;
   logic                          s_WLAST_o;
   logic                          s_WVALID_o;
   logic                          s_WREADY_i;
   logic                          wlast_err_o;
   logic [MST_ID_W-1:0]           wlast_err_mst_o;

   modport slave (
      input  dsp_WDATA_i, dsp_WSTRB_i, dsp_WLAST_i,
      input  dsp_WVALID_i, dsp_slv_sel_i,
      output dsp_WREADY_o,
      input  AW_mst_id_i, AW_AxLEN_i, AW_fifo_order_wr_en_i,
      output AW_stall_o,
      output s_WDATA_o, s_WSTRB_o, s_WLAST_o, s_WVALID_o,
      input  s_WREADY_i,
      output wlast_err_o, wlast_err_mst_o
   );

   modport master (
      output dsp_WDATA_i, dsp_WSTRB_i, dsp_WLAST_i,
      output dsp_WVALID_i, dsp_slv_sel_i,
      input  dsp_WREADY_o,
      output AW_mst_id_i, AW_AxLEN_i, AW_fifo_order_wr_en_i,
      input  AW_stall_o,
      input  s_WDATA_o, s_WSTRB_o, s_WLAST_o, s_WVALID_o,
      output s_WREADY_i,
      input  wlast_err_o, wlast_err_mst_o
   );
endinterface

// File: rtl/sa_wdata_steer_fifo.sv
// Show-ahead FIFO: o_rdata is the head entry whenever o_empty is low.
// Pushes while full and pops while empty are ignored.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_rdata = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end
endmodule

// File: rtl/sa_wdata_steer.sv
// Slave-side W steering: per-master beat buffers drained in AW grant
// order through one registered valid/ready output stage.
module sa_wdata_steer
   import sa_pkg::*;
#(
   parameter int MST_AMT          = 3,
   parameter int MST_ID_W         = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
   parameter int OUTSTANDING_AMT  = 8,
   parameter int WBUF_DEPTH       = 16,
   parameter int DATA_WIDTH       = 32,
   parameter int STRB_WIDTH       = DATA_WIDTH / 8,
   parameter int TRANS_DATA_LEN_W = 8
) (
   input logic             ACLK_i,
   input logic             ARESETn_i,
   sa_wdata_steer_if.slave bus
);
   localparam int OE_W = order_entry_w(MST_ID_W, TRANS_DATA_LEN_W);
   localparam int WE_W = wentry_w(DATA_WIDTH);
   localparam int NSEL = 1 << MST_ID_W;

   logic [OE_W-1:0]             w_ord_head;
   logic                        w_ord_full;
   logic                        w_ord_empty;
   logic                        w_ord_pop;
   logic [MST_ID_W-1:0]         w_cur_id;
   logic [TRANS_DATA_LEN_W-1:0] w_cur_len;

   logic [WE_W-1:0]    w_head [MST_AMT];
   logic [MST_AMT-1:0] w_full;
   logic [MST_AMT-1:0] w_empty;
   logic [MST_AMT-1:0] w_pop_buf;
   logic [WE_W-1:0]    w_head_pad [NSEL];
   logic [NSEL-1:0]    w_empty_pad;

   logic [WE_W-1:0]       w_sel;
   logic                  w_load_en;
   logic                  w_avail;
   logic                  w_fire;
   logic                  w_gen_last;

   logic [DATA_WIDTH-1:0]       r_data;
   logic [STRB_WIDTH-1:0]       r_strb;
   logic                        r_last;
   logic                        r_valid;
   logic                        r_err;
   logic [MST_ID_W-1:0]         r_err_mst;
   logic [TRANS_DATA_LEN_W-1:0] r_beat_cnt;

   fifo #(
      .WIDTH (OE_W),
      .DEPTH (OUTSTANDING_AMT)
   ) u_order (
      .i_clk   (ACLK_i),
      .i_rst_n (ARESETn_i),
      .i_push  (bus.AW_fifo_order_wr_en_i),
      .i_wdata ({bus.AW_mst_id_i, bus.AW_AxLEN_i}),
      .i_pop   (w_ord_pop),
      .o_rdata (w_ord_head),
      .o_full  (w_ord_full),
      .o_empty (w_ord_empty)
   );

   assign {w_cur_id, w_cur_len} = w_ord_head;
   assign bus.AW_stall_o = w_ord_full;

   for (genvar m = 0; m < MST_AMT; m++) begin : g_buf
      fifo #(
         .WIDTH (WE_W),
         .DEPTH (WBUF_DEPTH)
      ) u_wbuf (
         .i_clk   (ACLK_i),
         .i_rst_n (ARESETn_i),
         .i_push  (bus.dsp_WVALID_i[m] & bus.dsp_slv_sel_i[m] & ~w_full[m]),
         .i_wdata ({bus.dsp_WDATA_i[m*DATA_WIDTH +: DATA_WIDTH],
                    bus.dsp_WSTRB_i[m*STRB_WIDTH +: STRB_WIDTH],
                    bus.dsp_WLAST_i[m]}),
         .i_pop   (w_pop_buf[m]),
         .o_rdata (w_head[m]),
         .o_full  (w_full[m]),
         .o_empty (w_empty[m])
      );
   end

   assign bus.dsp_WREADY_o = ~w_full;

   // Ids with no buffer behind them read as permanently empty.
   always_comb begin
      w_empty_pad = '1;
      for (int m = 0; m < NSEL; m++) w_head_pad[m] = '0;
      for (int m = 0; m < MST_AMT; m++) begin
         w_empty_pad[m] = w_empty[m];
         w_head_pad[m]  = w_head[m];
      end
   end

   assign w_sel      = w_head_pad[w_cur_id];
   assign w_load_en  = ~r_valid | bus.s_WREADY_i;
   assign w_avail    = ~w_ord_empty & ~w_empty_pad[w_cur_id];
   assign w_fire     = w_load_en & w_avail;
   assign w_gen_last = (r_beat_cnt == w_cur_len);
   assign w_ord_pop  = w_fire & w_gen_last;

   always_comb begin
      w_pop_buf = '0;
      for (int m = 0; m < MST_AMT; m++)
         w_pop_buf[m] = w_fire && (w_cur_id == MST_ID_W'(m));
   end

   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         r_data     <= '0;
         r_strb     <= '0;
         r_last     <= 1'b0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_err_mst  <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_err <= w_fire & (w_sel[0] != w_gen_last);
         if (w_fire && (w_sel[0] != w_gen_last)) r_err_mst <= w_cur_id;
         if (w_load_en) begin
            r_valid <= w_avail;
            if (w_avail) begin
               r_data     <= w_sel[WE_W-1 -: DATA_WIDTH];
               r_strb     <= w_sel[STRB_WIDTH:1];
               r_last     <= w_gen_last;
               r_beat_cnt <= w_gen_last ? '0 : r_beat_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.s_WDATA_o       = r_data;
   assign bus.s_WSTRB_o       = r_strb;
   assign bus.s_WLAST_o       = r_last;
   assign bus.s_WVALID_o      = r_valid;
   assign bus.wlast_err_o     = r_err;
   assign bus.wlast_err_mst_o = r_err_mst;
endmodule

// File: tb/tb_sa_wdata_steer.sv
// Bench for sa_wdata_steer: burst table plus ordering, full, stall,
// WLAST-mismatch and mid-burst reset sequences against a beat scoreboard.
module tb_sa_wdata_steer;
   localparam int MA = 3;
   localparam int IW = 2;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int LW = 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic          l;
   } beat_t;

   typedef struct {
      int          id;
      int          len;
      logic [31:0] base;
      logic [3:0]  strb;
      bit          bp;
      int          lat;
      int          span;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   err_cnt = 0;
   int   err_mst = 0;
   int   first_v = 0;
   int   last_hs = 0;
   bit   first_armed = 1'b0;
   int   rdy_mode = 0;
   int   rdy_k = 0;
   beat_t sb[$];

   sa_wdata_steer_if #(
      .MST_AMT(MA), .MST_ID_W(IW), .DATA_WIDTH(DW),
      .STRB_WIDTH(SW), .TRANS_DATA_LEN_W(LW)
   ) bus ();

   sa_wdata_steer #(
      .MST_AMT(MA), .MST_ID_W(IW), .OUTSTANDING_AMT(8),
      .WBUF_DEPTH(16), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
      .TRANS_DATA_LEN_W(LW)
   ) dut (
      .ACLK_i    (clk),
      .ARESETn_i (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Slave ready: 0 = always 1, 1 = repeating 1,0,0,1, 2 = always 0.
   initial begin
      int seqv[4] = '{1, 0, 0, 1};
      bus.s_WREADY_i = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            1: begin
               bus.s_WREADY_i = seqv[rdy_k % 4][0];
               rdy_k++;
            end
            2: bus.s_WREADY_i = 1'b0;
            default: bus.s_WREADY_i = 1'b1;
         endcase
      end
   end

   // Output monitor: scoreboard pops, hold-while-stalled checks, err pulses.
   initial begin
      bit    stall_prev = 1'b0;
      beat_t prev;
      beat_t cur;
      beat_t exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            cur = {bus.s_WDATA_o, bus.s_WSTRB_o, bus.s_WLAST_o};
            if (bus.wlast_err_o) begin
               err_cnt++;
               err_mst = int'(bus.wlast_err_mst_o);
            end
            if (stall_prev) begin
               total++;
               if (bus.s_WVALID_o !== 1'b1 || cur !== prev) begin
                  bad++;
                  $display("FAIL hold: got v=%0b %h want v=1 %h",
                           bus.s_WVALID_o, cur, prev);
               end
            end
            if (bus.s_WVALID_o && first_armed) begin
               first_v = cyc;
               first_armed = 1'b0;
            end
            if (bus.s_WVALID_o && bus.s_WREADY_i) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL extra_beat: got %h want none", cur);
               end else begin
                  exp = sb.pop_front();
                  if (cur !== exp) begin
                     bad++;
                     $display("FAIL beat: got d=%h s=%h l=%b want d=%h s=%h l=%b",
                              cur.d, cur.s, cur.l, exp.d, exp.s, exp.l);
                  end
               end
               last_hs = cyc;
            end
            stall_prev = bus.s_WVALID_o & ~bus.s_WREADY_i;
            prev = cur;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_aw(int id, int len);
      @(negedge clk);
      bus.AW_mst_id_i = IW'(id);
      bus.AW_AxLEN_i = LW'(len);
      bus.AW_fifo_order_wr_en_i = 1'b1;
      @(posedge clk);
      #1;
      bus.AW_fifo_order_wr_en_i = 1'b0;
   endtask

   task automatic exp_burst(logic [31:0] base, logic [3:0] strb, int len);
      for (int i = 0; i <= len; i++)
         sb.push_back({base + 32'(i), strb, (i == len)});
   endtask

   task automatic send_beat(int m, logic [31:0] d, logic [3:0] s,
                            logic l, output int hs);
      int guard = 0;
      @(negedge clk);
      bus.dsp_WDATA_i[m*DW +: DW] = d;
      bus.dsp_WSTRB_i[m*SW +: SW] = s;
      bus.dsp_WLAST_i[m] = l;
      bus.dsp_WVALID_i[m] = 1'b1;
      bus.dsp_slv_sel_i[m] = 1'b1;
      while (!bus.dsp_WREADY_o[m] && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) begin
         total++;
         bad++;
         $display("FAIL wready_wait: got timeout want handshake m=%0d", m);
      end
      @(posedge clk);
      #1;
      hs = cyc;
      bus.dsp_WVALID_i[m] = 1'b0;
      bus.dsp_slv_sel_i[m] = 1'b0;
   endtask

   task automatic wait_drain(int budget);
      int g = 0;
      while (sb.size() != 0 && g < budget) begin
         @(negedge clk);
         #1;
         g++;
      end
      chk("drain_left", 64'(sb.size()), 0);
      sb.delete();
   endtask

   initial begin
      vec_t vec[5];
      int   hs;
      int   hs0;
      vec[0] = '{id:1, len:3,   base:32'hA0,   strb:4'hF, bp:0, lat:1, span:4};
      vec[1] = '{id:2, len:0,   base:32'hC0,   strb:4'h3, bp:0, lat:1, span:1};
      vec[2] = '{id:0, len:7,   base:32'h1000, strb:4'h5, bp:0, lat:1, span:8};
      vec[3] = '{id:1, len:3,   base:32'hB0,   strb:4'hF, bp:1, lat:1, span:0};
      vec[4] = '{id:2, len:255, base:32'h2000, strb:4'hA, bp:0, lat:1, span:256};

      bus.dsp_WDATA_i = '0;
      bus.dsp_WSTRB_i = '0;
      bus.dsp_WLAST_i = '0;
      bus.dsp_WVALID_i = '0;
      bus.dsp_slv_sel_i = '0;
      bus.AW_mst_id_i = '0;
      bus.AW_AxLEN_i = '0;
      bus.AW_fifo_order_wr_en_i = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(bus.s_WVALID_o), 0);
      chk("rst_last", 64'(bus.s_WLAST_o), 0);
      chk("rst_data", 64'(bus.s_WDATA_o), 0);
      chk("rst_strb", 64'(bus.s_WSTRB_o), 0);
      chk("rst_err", 64'({bus.wlast_err_o, bus.wlast_err_mst_o}), 0);
      chk("rst_wready", 64'(bus.dsp_WREADY_o), 64'h7);
      chk("rst_stall", 64'(bus.AW_stall_o), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_valid", 64'(bus.s_WVALID_o), 0);

      for (int t = 0; t < 5; t++) begin
         rdy_k = 0;
         rdy_mode = vec[t].bp ? 1 : 0;
         push_aw(vec[t].id, vec[t].len);
         exp_burst(vec[t].base, vec[t].strb, vec[t].len);
         first_armed = 1'b1;
         hs0 = 0;
         for (int i = 0; i <= vec[t].len; i++) begin
            send_beat(vec[t].id, vec[t].base + 32'(i), vec[t].strb,
                      (i == vec[t].len), hs);
            if (i == 0) hs0 = hs;
         end
         wait_drain(600);
         chk($sformatf("lat_%0d", t), 64'(first_v - hs0), 64'(vec[t].lat));
         if (vec[t].span != 0)
            chk($sformatf("span_%0d", t), 64'(last_hs - first_v + 1),
                64'(vec[t].span));
         rdy_mode = 0;
         repeat (2) @(negedge clk);
      end

      // Grant order wins over arrival order; no bubble at the switch.
      push_aw(2, 0);
      push_aw(0, 1);
      exp_burst(32'h300, 4'hF, 0);
      exp_burst(32'h200, 4'hF, 1);
      first_armed = 1'b1;
      send_beat(0, 32'h200, 4'hF, 1'b0, hs);
      send_beat(0, 32'h201, 4'hF, 1'b1, hs);
      send_beat(2, 32'h300, 4'hF, 1'b1, hs);
      wait_drain(50);
      chk("order_span", 64'(last_hs - first_v + 1), 3);
      repeat (2) @(negedge clk);

      // Master 0 buffer fills with no order entry.
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("wready_15", 64'(bus.dsp_WREADY_o), 64'h7);
         send_beat(0, 32'h400 + 32'(i), 4'hC, (i == 15), hs);
      end
      @(negedge clk);
      chk("wready_full", 64'(bus.dsp_WREADY_o), 64'h6);
      push_aw(0, 15);
      exp_burst(32'h400, 4'hC, 15);
      wait_drain(100);
      chk("wready_drained", 64'(bus.dsp_WREADY_o), 64'h7);

      // Order FIFO full; stall drops once the first burst pops.
      for (int k = 0; k < 8; k++) begin
         if (k == 7) chk("stall_7", 64'(bus.AW_stall_o), 0);
         push_aw(1, 0);
         exp_burst(32'h500 + 32'(k), 4'hF, 0);
      end
      chk("stall_8", 64'(bus.AW_stall_o), 1);
      send_beat(1, 32'h500, 4'hF, 1'b1, hs);
      @(negedge clk);
      chk("stall_hs", 64'(bus.AW_stall_o), 1);
      @(negedge clk);
      chk("stall_drop", 64'(bus.AW_stall_o), 0);
      for (int k = 1; k < 8; k++)
         send_beat(1, 32'h500 + 32'(k), 4'hF, 1'b1, hs);
      wait_drain(50);
      repeat (2) @(negedge clk);

      // Early WLAST from master 2.
      chk("no_err_yet", 64'(err_cnt), 0);
      push_aw(2, 1);
      exp_burst(32'h600, 4'h1, 1);
      send_beat(2, 32'h600, 4'h1, 1'b1, hs);
      send_beat(2, 32'h601, 4'h1, 1'b1, hs);
      wait_drain(50);
      repeat (2) @(negedge clk);
      chk("err_pulses", 64'(err_cnt), 1);
      chk("err_mst", 64'(err_mst), 2);

      // Reset in the middle of a stalled burst.
      rdy_mode = 2;
      push_aw(0, 3);
      send_beat(0, 32'h700, 4'hF, 1'b0, hs);
      send_beat(0, 32'h701, 4'hF, 1'b0, hs);
      @(negedge clk);
      chk("pre_rst_valid", 64'(bus.s_WVALID_o), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.s_WVALID_o), 0);
      chk("arst_data", 64'({bus.s_WDATA_o, bus.s_WSTRB_o, bus.s_WLAST_o}), 0);
      chk("arst_wready", 64'(bus.dsp_WREADY_o), 64'h7);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rdy_mode = 0;
      push_aw(0, 0);
      exp_burst(32'h800, 4'h9, 0);
      send_beat(0, 32'h800, 4'h9, 1'b1, hs);
      wait_drain(50);
      repeat (3) @(negedge clk);
      chk("post_rst_valid_idle", 64'(bus.s_WVALID_o), 0);
      chk("post_rst_err", 64'(err_cnt), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
